id_ex_reg: RTL and testbench

//   ID/EX pipeline register of the 5-stage RISC-V core. Captures the 8-bit control word from

---
 rtl/id_ex_reg.sv | 103 ++++++++++
 tb/tb_id_ex_reg.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_reg.sv
// ID/EX pipeline register: bubble/flush/stall handling plus a combinational load-use hazard flag.
// Optional perf counters (stall and bubble) are built only when ID_EX_PERF_EN is defined.
module id_ex_reg #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int CTRL_W = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              stall_i,
  input  logic              flush_i,
  input  logic              valid_i,
  input  logic [CTRL_W-1:0] ctrl_i,
  input  logic [9:0]        funct_i,
  input  logic [DATA_W-1:0] pc_i,
  input  logic [DATA_W-1:0] rs1_data_i,
  input  logic [DATA_W-1:0] rs2_data_i,
  input  logic [DATA_W-1:0] imm_i,
  input  logic [REG_AW-1:0] rs1_addr_i,
  input  logic [REG_AW-1:0] rs2_addr_i,
  input  logic [REG_AW-1:0] rd_addr_i,
  output logic              valid_o,
  output logic [CTRL_W-1:0] ctrl_o,
  output logic [9:0]        funct_o,
  output logic [DATA_W-1:0] pc_o,
  output logic [DATA_W-1:0] rs1_data_o,
  output logic [DATA_W-1:0] rs2_data_o,
  output logic [DATA_W-1:0] imm_o,
  output logic [REG_AW-1:0] rs1_addr_o,
  output logic [REG_AW-1:0] rs2_addr_o,
  output logic [REG_AW-1:0] rd_addr_o,
  output logic              load_use_o,
  output logic [31:0]       stall_cnt_o,
  output logic [31:0]       bubble_cnt_o
);

  localparam int MEM_READ_BIT = 5;

  logic in_bubble;
  logic load_bubble;

  // An entry without a real instruction or with an all-zero control word carries no side effects.
  assign in_bubble   = ~valid_i | (ctrl_i == '0);
  assign load_bubble = ~stall_i & in_bubble;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      valid_o    <= 1'b0;
      ctrl_o     <= '0;
      funct_o    <= '0;
      pc_o       <= '0;
      rs1_data_o <= '0;
      rs2_data_o <= '0;
      imm_o      <= '0;
      rs1_addr_o <= '0;
      rs2_addr_o <= '0;
      rd_addr_o  <= '0;
    end else if (!stall_i) begin
      valid_o    <= ~in_bubble;
      ctrl_o     <= in_bubble ? '0 : ctrl_i;
      rd_addr_o  <= in_bubble ? '0 : rd_addr_i;
      funct_o    <= funct_i;
      pc_o       <= pc_i;
      rs1_data_o <= rs1_data_i;
      rs2_data_o <= rs2_data_i;
      imm_o      <= imm_i;
      rs1_addr_o <= rs1_addr_i;
      rs2_addr_o <= rs2_addr_i;
    end
  end

  // A load in EX whose destination is read by the instruction now in ID; x0 never conflicts.
  assign load_use_o = valid_o & ctrl_o[MEM_READ_BIT] & (rd_addr_o != '0) &
                      ((rd_addr_o == rs1_addr_i) | (rd_addr_o == rs2_addr_i));

`ifdef ID_EX_PERF_EN
  logic [31:0] stall_cnt_q;
  logic [31:0] bubble_cnt_q;

  // Both counters saturate rather than wrap, so a long run never reads as a short one.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      if (stall_i && !flush_i && (stall_cnt_q != '1))
        stall_cnt_q <= stall_cnt_q + 32'd1;
      if ((flush_i || load_bubble) && (bubble_cnt_q != '1))
        bubble_cnt_q <= bubble_cnt_q + 32'd1;
    end
  end

  assign stall_cnt_o  = stall_cnt_q;
  assign bubble_cnt_o = bubble_cnt_q;
`else
  logic unused_perf;
  assign unused_perf  = load_bubble;
  assign stall_cnt_o  = 32'h0;
  assign bubble_cnt_o = 32'h0;
`endif

endmodule

// File: tb/tb_id_ex_reg.sv
// Randomized bench for id_ex_reg against a transaction-level model of the stage contents.
module tb_id_ex_reg;

  localparam int DATA_W = 32;
  localparam int REG_AW = 5;
  localparam int CTRL_W = 8;
`ifdef ID_EX_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic              clk_i = 1'b0;
  logic              rst_i, stall_i, flush_i, valid_i;
  logic [CTRL_W-1:0] ctrl_i;
  logic [9:0]        funct_i;
  logic [DATA_W-1:0] pc_i, rs1_data_i, rs2_data_i, imm_i;
  logic [REG_AW-1:0] rs1_addr_i, rs2_addr_i, rd_addr_i;
  logic              valid_o, load_use_o;
  logic [CTRL_W-1:0] ctrl_o;
  logic [9:0]        funct_o;
  logic [DATA_W-1:0] pc_o, rs1_data_o, rs2_data_o, imm_o;
  logic [REG_AW-1:0] rs1_addr_o, rs2_addr_o, rd_addr_o;
  logic [31:0]       stall_cnt_o, bubble_cnt_o;

  always #5 clk_i = ~clk_i;

  id_ex_reg #(.DATA_W(DATA_W), .REG_AW(REG_AW), .CTRL_W(CTRL_W)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .stall_i(stall_i), .flush_i(flush_i), .valid_i(valid_i),
    .ctrl_i(ctrl_i), .funct_i(funct_i), .pc_i(pc_i), .rs1_data_i(rs1_data_i),
    .rs2_data_i(rs2_data_i), .imm_i(imm_i), .rs1_addr_i(rs1_addr_i), .rs2_addr_i(rs2_addr_i),
    .rd_addr_i(rd_addr_i), .valid_o(valid_o), .ctrl_o(ctrl_o), .funct_o(funct_o), .pc_o(pc_o),
    .rs1_data_o(rs1_data_o), .rs2_data_o(rs2_data_o), .imm_o(imm_o), .rs1_addr_o(rs1_addr_o),
    .rs2_addr_o(rs2_addr_o), .rd_addr_o(rd_addr_o), .load_use_o(load_use_o),
    .stall_cnt_o(stall_cnt_o), .bubble_cnt_o(bubble_cnt_o)
  );

  typedef struct packed {
    logic        valid;
    logic [7:0]  ctrl;
    logic [9:0]  funct;
    logic [31:0] pc;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [31:0] imm;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [4:0]  rd_addr;
  } stage_t;

  stage_t      model;
  logic [31:0] exp_stalls, exp_bubbles;
  int          vectors = 0;
  int          miscompares = 0;

  function automatic stage_t observed();
    stage_t s;
    s.valid = valid_o;       s.ctrl = ctrl_o;         s.funct = funct_o;
    s.pc = pc_o;             s.rs1_data = rs1_data_o; s.rs2_data = rs2_data_o;
    s.imm = imm_o;           s.rs1_addr = rs1_addr_o; s.rs2_addr = rs2_addr_o;
    s.rd_addr = rd_addr_o;
    return s;
  endfunction

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  // Hazard exists when EX holds a real load to a nonzero register that ID is about to read.
  function automatic logic exp_load_use();
    return model.valid && model.ctrl[5] && (model.rd_addr != 5'd0) &&
           ((model.rd_addr == rs1_addr_i) || (model.rd_addr == rs2_addr_i));
  endfunction

  function automatic logic [31:0] exp_stall_cnt();
    return PERF ? exp_stalls : 32'h0;
  endfunction

  function automatic logic [31:0] exp_bubble_cnt();
    return PERF ? exp_bubbles : 32'h0;
  endfunction

  task automatic model_edge();
    if (rst_i) begin
      model = '0; exp_stalls = '0; exp_bubbles = '0;
    end else if (flush_i) begin
      model = '0; exp_bubbles = sat_inc(exp_bubbles);
    end else if (stall_i) begin
      exp_stalls = sat_inc(exp_stalls);
    end else begin
      model = '{valid: 1'b1, ctrl: ctrl_i, funct: funct_i, pc: pc_i, rs1_data: rs1_data_i,
                rs2_data: rs2_data_i, imm: imm_i, rs1_addr: rs1_addr_i,
                rs2_addr: rs2_addr_i, rd_addr: rd_addr_i};
      if (!valid_i || ctrl_i == 8'h00) begin
        model.valid = 1'b0; model.ctrl = '0; model.rd_addr = '0;
        exp_bubbles = sat_inc(exp_bubbles);
      end
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    model_edge();
    #1;
  endtask

  task automatic rand_inputs();
    valid_i    = ($urandom_range(0, 4) != 0);
    ctrl_i     = ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom);
    funct_i    = 10'($urandom);
    pc_i       = $urandom;
    rs1_data_i = $urandom;
    rs2_data_i = $urandom;
    imm_i      = $urandom;
    rs1_addr_i = 5'($urandom_range(0, 7));
    rs2_addr_i = 5'($urandom_range(0, 7));
    rd_addr_i  = 5'($urandom_range(0, 7));
  endtask

  task automatic test_reset();
    rand_inputs();
    rst_i = 1'b1; stall_i = 1'($urandom); flush_i = 1'($urandom);
    repeat (2) begin
      step();
      rand_inputs();
      vectors++;
      if (observed() !== stage_t'('0)) begin
        miscompares++; $display("FAIL reset_regs: got %h want 0", observed());
      end
    end
    #1;
    vectors++;
    if (load_use_o !== 1'b0) begin
      miscompares++; $display("FAIL reset_load_use: got %b want 0", load_use_o);
    end
    vectors++;
    if ({stall_cnt_o, bubble_cnt_o} !== 64'h0) begin
      miscompares++; $display("FAIL reset_counters: got %h/%h want 0/0", stall_cnt_o, bubble_cnt_o);
    end
    rst_i = 1'b0; stall_i = 1'b0; flush_i = 1'b0;
  endtask

  task automatic test_pass_through();
    rand_inputs();
    valid_i = 1'b1; ctrl_i = 8'b1000_0000; rd_addr_i = 5'd5; imm_i = 32'h10;
    step();
    vectors++;
    if ({valid_o, ctrl_o, rd_addr_o, imm_o} !== {1'b1, 8'h80, 5'd5, 32'h10}) begin
      miscompares++;
      $display("FAIL pass_through: got v=%b c=%h rd=%0d imm=%h want v=1 c=80 rd=5 imm=10",
               valid_o, ctrl_o, rd_addr_o, imm_o);
    end
    vectors++;
    if (observed() !== model) begin
      miscompares++; $display("FAIL pass_through_fields: got %h want %h", observed(), model);
    end
  endtask

  task automatic test_load_use();
    rand_inputs();
    valid_i = 1'b1; ctrl_i = 8'hE2; rd_addr_i = 5'd7;
    step();
    rs1_addr_i = 5'd7; rs2_addr_i = 5'd3;
    #1;
    vectors++;
    if (load_use_o !== 1'b1) begin
      miscompares++; $display("FAIL load_use_rs1: got %b want 1", load_use_o);
    end
    rs1_addr_i = 5'd2; rs2_addr_i = 5'd7;
    #1;
    vectors++;
    if (load_use_o !== 1'b1) begin
      miscompares++; $display("FAIL load_use_rs2: got %b want 1", load_use_o);
    end
    rs2_addr_i = 5'd6;
    #1;
    vectors++;
    if (load_use_o !== 1'b0) begin
      miscompares++; $display("FAIL load_use_nomatch: got %b want 0", load_use_o);
    end
    // Hazard unit's response: noop control word with ID still reading x7.
    rs1_addr_i = 5'd7; ctrl_i = 8'h00;
    step();
    vectors++;
    if ({valid_o, ctrl_o, rd_addr_o, load_use_o} !== {1'b0, 8'h00, 5'd0, 1'b0}) begin
      miscompares++;
      $display("FAIL load_use_bubble: got v=%b c=%h rd=%0d lu=%b want 0/00/0/0",
               valid_o, ctrl_o, rd_addr_o, load_use_o);
    end
  endtask

  task automatic test_x0_load();
    rand_inputs();
    valid_i = 1'b1; ctrl_i = 8'hE2; rd_addr_i = 5'd0;
    step();
    rs1_addr_i = 5'd0; rs2_addr_i = 5'd0;
    #1;
    vectors++;
    if ({valid_o, load_use_o} !== 2'b10) begin
      miscompares++; $display("FAIL x0_load: got v=%b lu=%b want v=1 lu=0", valid_o, load_use_o);
    end
  endtask

  task automatic test_stall_flush();
    stage_t held;
    rand_inputs();
    valid_i = 1'b1; ctrl_i = 8'hA6;
    step();
    held = observed();
    vectors++;
    if (held !== model) begin
      miscompares++; $display("FAIL stall_setup: got %h want %h", held, model);
    end
    repeat (3) begin
      rand_inputs();
      stall_i = 1'b1;
      step();
      vectors++;
      if (observed() !== held || model !== held) begin
        miscompares++; $display("FAIL stall_hold: got %h want %h", observed(), held);
      end
    end
    rand_inputs();
    valid_i = 1'b1; ctrl_i = 8'hE2; stall_i = 1'b1; flush_i = 1'b1;
    step();
    vectors++;
    if (observed() !== stage_t'('0)) begin
      miscompares++; $display("FAIL flush_over_stall: got %h want 0", observed());
    end
    // Reset asserted on top of stall and flush leaves an empty stage.
    rand_inputs();
    valid_i = 1'b1; ctrl_i = 8'h80;
    step();
    rst_i = 1'b1;
    step();
    rst_i = 1'b0; stall_i = 1'b0; flush_i = 1'b0;
    vectors++;
    if ({observed(), stall_cnt_o, bubble_cnt_o} !== '0) begin
      miscompares++;
      $display("FAIL reset_mid_stall: got %h %h/%h want 0", observed(), stall_cnt_o, bubble_cnt_o);
    end
  endtask

  task automatic test_back_to_back();
    rand_inputs();
    for (int i = 0; i < 300; i++) begin
      rst_i   = ($urandom_range(0, 39) == 0);
      flush_i = ($urandom_range(0, 7) == 0);
      stall_i = ($urandom_range(0, 3) == 0);
      step();
      vectors++;
      if (observed() !== model) begin
        miscompares++; $display("FAIL random_regs[%0d]: got %h want %h", i, observed(), model);
      end
      rand_inputs();
      #1;
      vectors++;
      if (load_use_o !== exp_load_use()) begin
        miscompares++; $display("FAIL random_load_use[%0d]: got %b want %b", i, load_use_o, exp_load_use());
      end
      vectors++;
      if ({stall_cnt_o, bubble_cnt_o} !== {exp_stall_cnt(), exp_bubble_cnt()}) begin
        miscompares++;
        $display("FAIL random_counters[%0d]: got %0d/%0d want %0d/%0d", i,
                 stall_cnt_o, bubble_cnt_o, exp_stall_cnt(), exp_bubble_cnt());
      end
    end
    rst_i = 1'b0; stall_i = 1'b0; flush_i = 1'b0;
  endtask

  task automatic test_perf();
    rand_inputs();
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    valid_i = 1'b1; ctrl_i = 8'h82;
    step();
    stall_i = 1'b1;
    repeat (3) step();
    stall_i = 1'b0;
    valid_i = 1'b0;
    step();
    valid_i = 1'b1; ctrl_i = 8'h00;
    step();
    vectors++;
    if ({stall_cnt_o, bubble_cnt_o} !== {PERF ? 32'd3 : 32'd0, PERF ? 32'd2 : 32'd0}) begin
      miscompares++;
      $display("FAIL perf_counts: got %0d/%0d want %0d/%0d", stall_cnt_o, bubble_cnt_o,
               PERF ? 3 : 0, PERF ? 2 : 0);
    end
`ifdef ID_EX_PERF_EN
    force dut.stall_cnt_q = 32'hFFFF_FFFE;
    #1;
    release dut.stall_cnt_q;
    exp_stalls = 32'hFFFF_FFFE;
    stall_i = 1'b1;
    repeat (3) step();
    stall_i = 1'b0;
    vectors++;
    if (stall_cnt_o !== 32'hFFFF_FFFF) begin
      miscompares++; $display("FAIL perf_saturate: got %h want ffffffff", stall_cnt_o);
    end
`endif
  endtask

  initial begin
    rst_i = 1'b1; stall_i = 1'b0; flush_i = 1'b0;
    model = '0; exp_stalls = '0; exp_bubbles = '0;
    rand_inputs();
    test_reset();
    test_pass_through();
    test_load_use();
    test_x0_load();
    test_stall_flush();
    test_back_to_back();
    test_perf();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
